// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine: opcodes, controller states and
// datapath select codes, used by the controller, the decoder and the datapath.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RN   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_LOAD_IR,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_C,
        S_ADDR,
        S_MEM_RD,
        S_LDR_WB,
        S_GET_RD,
        S_PASS,
        S_MEM_WR,
        S_HALT
    } state_t;

endpackage

// File: rtl/cpu_controller_pc_ir_reg.sv
// Program counter, instruction register and store-address register, each with
// its own load enable supplied by the controller FSM.
module pc_ir_reg
    import cpu_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_ir,
    input  logic              load_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] ir,
    output logic [ADDR_W-1:0] addr_reg
);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; all three registers are small and get an explicit reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            ir       <= '0;
            addr_reg <= '0;
        end else begin
            if (load_ir) begin
                ir <= mem_rdata;
                pc <= pc + ADDR_W'(1);
            end
            if (load_addr) begin
                addr_reg <= addr_in;
            end
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Multicycle fetch/decode/execute controller for the Simple RISC Machine.
// Optional retired-instruction counter is enabled by defining CPU_CTRL_RETIRE_CNT_EN.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step_en,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic [WORD_W-1:0] datapath_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] instruction,
    output logic [2:0]        nsel,
    output logic [1:0]        vsel,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic              is_mov;
    logic              is_cmp;

    assign opcode    = instruction[15:13];
    assign op        = instruction[12:11];
    assign is_mov    = (opcode == OPC_MOV);
    assign is_cmp    = (opcode == OPC_ALU) && (op == OP_CMP);
    assign halted    = (state == S_HALT);
    assign mem_wdata = datapath_out;

    pc_ir_reg #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_ir_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_ir   (step_en && (state == S_LOAD_IR)),
        .load_addr (step_en && (state == S_GET_RD)),
        .mem_rdata (mem_rdata),
        .addr_in   (datapath_out[ADDR_W-1:0]),
        .pc        (pc),
        .ir        (instruction),
        .addr_reg  (addr_reg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else if (step_en) begin
            case (state)
                S_FETCH:   state <= S_LOAD_IR;
                S_LOAD_IR: state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OPC_MOV: begin
                            if (op == OP_MOV_IMM)      state <= S_WR_IMM;
                            else if (op == OP_MOV_REG) state <= S_GET_B;
                            else                       state <= S_HALT;
                        end
                        OPC_ALU, OPC_LDR, OPC_STR: state <= S_GET_A;
                        default:                   state <= S_HALT;
                    endcase
                end
                S_WR_IMM:  state <= S_FETCH;
                S_GET_A:   state <= (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
                S_GET_B:   state <= S_EXEC;
                S_EXEC:    state <= is_cmp ? S_FETCH : S_WR_C;
                S_WR_C:    state <= S_FETCH;
                S_ADDR:    state <= (opcode == OPC_LDR) ? S_MEM_RD : S_GET_RD;
                S_MEM_RD:  state <= S_LDR_WB;
                S_LDR_WB:  state <= S_FETCH;
                S_GET_RD:  state <= S_PASS;
                S_PASS:    state <= S_MEM_WR;
                S_MEM_WR:  state <= S_FETCH;
                default:   state <= S_HALT;
            endcase
        end
    end

    // Strobes are gated by step_en so a frozen FSM never repeats a load or write;
    // selects and the RAM address stay stable while frozen.
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        nsel     = NSEL_NONE;
        vsel     = VSEL_C;
        asel     = 1'b0;
        bsel     = 1'b0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc;
        case (state)
            S_WR_IMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = step_en;
            end
            S_GET_A: begin
                nsel  = NSEL_RN;
                loada = step_en;
            end
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = step_en;
            end
            S_EXEC: begin
                asel  = is_mov;
                loads = step_en && is_cmp;
                loadc = step_en && !is_cmp;
            end
            S_WR_C: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = step_en;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = step_en;
            end
            S_MEM_RD: mem_addr = datapath_out[ADDR_W-1:0];
            S_LDR_WB: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_MDATA;
                write = step_en;
            end
            S_GET_RD: begin
                nsel  = NSEL_RD;
                loadb = step_en;
            end
            S_PASS: begin
                asel  = 1'b1;
                loadc = step_en;
            end
            S_MEM_WR: begin
                mem_addr = addr_reg;
                mem_we   = step_en;
            end
            default: ;
        endcase
    end

`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic instr_done;

    // States whose successor is FETCH mark the last cycle of an instruction.
    always_comb begin
        case (state)
            S_WR_IMM, S_WR_C, S_LDR_WB, S_MEM_WR: instr_done = 1'b1;
            S_EXEC:                               instr_done = is_cmp;
            default:                              instr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (step_en && instr_done && (retired != '1)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a small datapath and RAM model run real
// programs; expected strobe events are queued and matched by a negedge monitor.
module tb_cpu_controller;
    import cpu_pkg::*;

    localparam logic [5:0] EV_W  = 6'b100000;
    localparam logic [5:0] EV_LA = 6'b010000;
    localparam logic [5:0] EV_LB = 6'b001000;
    localparam logic [5:0] EV_LC = 6'b000100;
    localparam logic [5:0] EV_LS = 6'b000010;
    localparam logic [5:0] EV_MW = 6'b000001;

    typedef struct {
        int          cyc;
        logic [5:0]  strb;
        logic [2:0]  nsel;
        logic [1:0]  vsel;
        logic        asel;
        logic        bsel;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        step_en = 1'b0;
    logic [15:0] mem_rdata;
    logic [15:0] datapath_out;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] instruction;
    logic [2:0]  nsel;
    logic [1:0]  vsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [7:0]  pc;
    logic        halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_lo = -1;
    int   stall_hi = -1;
    int   push_limit = 1 << 30;
    ev_t  q[$];

    always #5 clk = ~clk;

    cpu_controller #(
        .WORD_W   (16),
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .step_en      (step_en),
        .mem_rdata    (mem_rdata),
        .datapath_out (datapath_out),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .instruction  (instruction),
        .nsel         (nsel),
        .vsel         (vsel),
        .write        (write),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .loads        (loads),
        .asel         (asel),
        .bsel         (bsel),
        .pc           (pc),
        .halted       (halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
        ,
        .retired      (retired)
`endif
    );

    // Program image; unlisted addresses hold MOV R7,#addr filler.
    function automatic logic [15:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 16'hD005; // MOV R0,#5
            8'h01:   rom = 16'hD103; // MOV R1,#3
            8'h02:   rom = 16'hA140; // ADD R2,R1,R0
            8'h03:   rom = 16'hD110; // MOV R1,#0x10
            8'h04:   rom = 16'hD440; // MOV R4,#0x40
            8'h05:   rom = 16'h6460; // LDR R3,[R4,#0]
            8'h06:   rom = 16'h8162; // STR R3,[R1,#2]
            8'h07:   rom = 16'h61A2; // LDR R5,[R1,#2]
            8'h08:   rom = 16'hAA00; // CMP R2,R0
            8'h09:   rom = 16'hB2C1; // AND R6,R2,R1
            8'h40:   rom = 16'hABCD; // data word, also fetched later as CMP R3,R5
            8'hFF:   rom = 16'hE000; // HALT
            default: rom = {8'hD7, a};
        endcase
    endfunction

    logic [15:0] ram [256];
    logic        written [256];
    logic        ram_clear = 1'b0;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : rom(mem_addr);
    end

    // Minimal datapath: register file, A/B/C registers and a 4-op ALU.
    logic [15:0] regs [8];
    logic [15:0] ra, rb, rc;
    logic [2:0]  rsel;
    logic [15:0] wval, sximm8, sximm5, ain, bin, alu;

    always_comb begin
        rsel   = nsel[0] ? instruction[2:0] : (nsel[1] ? instruction[7:5] : instruction[10:8]);
        sximm8 = {{8{instruction[7]}}, instruction[7:0]};
        sximm5 = {{11{instruction[4]}}, instruction[4:0]};
        case (vsel)
            2'b00:   wval = rc;
            2'b01:   wval = {8'h00, pc};
            2'b10:   wval = sximm8;
            default: wval = mem_rdata;
        endcase
        ain = asel ? 16'h0000 : ra;
        bin = bsel ? sximm5 : rb;
        case (instruction[12:11])
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) regs[rsel] <= wval;
        if (loada) ra <= regs[rsel];
        if (loadb) rb <= regs[rsel];
        if (loadc) rc <= alu;
    end

    assign datapath_out = rc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [5:0] s, input logic [2:0] n, input logic [1:0] v,
                        input logic a, input logic b, input logic [7:0] ad, input logic [15:0] d,
                        input logic [7:0] p);
        ev_t e;
        e.cyc = c; e.strb = s; e.nsel = n; e.vsel = v; e.asel = a; e.bsel = b;
        e.addr = ad; e.data = d; e.pc = p;
        if (c < push_limit) q.push_back(e);
    endtask

    // Hand-derived event timeline for addresses 0x00..0x09 (stall in cycles 56-57).
    task automatic push_program();
        push( 4, EV_W,  NSEL_RN, VSEL_IMM,   0, 0, 8'h00, 16'h0005, 8'h01);
        push( 8, EV_W,  NSEL_RN, VSEL_IMM,   0, 0, 8'h00, 16'h0003, 8'h02);
        push(12, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h03);
        push(13, EV_LB, NSEL_RM, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h03);
        push(14, EV_LC, 3'b000,  2'b00,      0, 0, 8'h00, 16'h0000, 8'h03);
        push(15, EV_W,  NSEL_RD, VSEL_C,     0, 0, 8'h00, 16'h0008, 8'h03);
        push(19, EV_W,  NSEL_RN, VSEL_IMM,   0, 0, 8'h00, 16'h0010, 8'h04);
        push(23, EV_W,  NSEL_RN, VSEL_IMM,   0, 0, 8'h00, 16'h0040, 8'h05);
        push(27, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h06);
        push(28, EV_LC, 3'b000,  2'b00,      0, 1, 8'h00, 16'h0000, 8'h06);
        push(30, EV_W,  NSEL_RD, VSEL_MDATA, 0, 0, 8'h00, 16'hABCD, 8'h06);
        push(34, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h07);
        push(35, EV_LC, 3'b000,  2'b00,      0, 1, 8'h00, 16'h0000, 8'h07);
        push(36, EV_LB, NSEL_RD, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h07);
        push(37, EV_LC, 3'b000,  2'b00,      1, 0, 8'h00, 16'h0000, 8'h07);
        push(38, EV_MW, 3'b000,  2'b00,      0, 0, 8'h12, 16'hABCD, 8'h07);
        push(42, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h08);
        push(43, EV_LC, 3'b000,  2'b00,      0, 1, 8'h00, 16'h0000, 8'h08);
        push(45, EV_W,  NSEL_RD, VSEL_MDATA, 0, 0, 8'h00, 16'hABCD, 8'h08);
        push(49, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h09);
        push(50, EV_LB, NSEL_RM, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h09);
        push(51, EV_LS, 3'b000,  2'b00,      0, 0, 8'h00, 16'h0000, 8'h09);
        push(55, EV_LA, NSEL_RN, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h0A);
        push(58, EV_LB, NSEL_RM, 2'b00,      0, 0, 8'h00, 16'h0000, 8'h0A);
        push(59, EV_LC, 3'b000,  2'b00,      0, 0, 8'h00, 16'h0000, 8'h0A);
        push(60, EV_W,  NSEL_RD, VSEL_C,     0, 0, 8'h00, 16'h0000, 8'h0A);
    endtask

    logic [5:0] strb;
    assign strb = {write, loada, loadb, loadc, loads, mem_we};

    always @(negedge clk) begin : monitor
        ev_t e;
        bit  ok;
        if (strb != 6'b0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d strb=%b pc=%h", cyc, strb, pc);
            end else begin
                e  = q.pop_front();
                ok = (cyc == e.cyc) && (strb == e.strb) && (pc == e.pc);
                if (e.strb[5] || e.strb[4] || e.strb[3]) ok = ok && (nsel == e.nsel);
                if (e.strb[5]) ok = ok && (vsel == e.vsel) && (wval == e.data);
                if (e.strb[2]) ok = ok && (asel == e.asel) && (bsel == e.bsel);
                if (e.strb[0]) ok = ok && (mem_addr == e.addr) && (mem_wdata == e.data);
                if (!ok) begin
                    errors++;
                    $display("FAIL strobe_event got/exp cyc=%0d/%0d strb=%b/%b nsel=%b/%b vsel=%b/%b asel=%b/%b bsel=%b/%b addr=%h/%h wval=%h wdata=%h exp_data=%h pc=%h/%h",
                             cyc, e.cyc, strb, e.strb, nsel, e.nsel, vsel, e.vsel, asel, e.asel,
                             bsel, e.bsel, mem_addr, e.addr, wval, mem_wdata, e.data, pc, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        step_en = !((cyc >= stall_lo) && (cyc <= stall_hi));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 1;
        step_en = 1'b1;
    endtask

    initial begin
        int t;
        int halt_cyc;

        // Reset state while reset_n is held low.
        reset_n   = 1'b0;
        step_en   = 1'b0;
        ram_clear = 1'b1;
        @(posedge clk);
        #1;
        ram_clear = 1'b0;
        check("rst_mem_addr", 32'(mem_addr), 32'h00);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_instruction", 32'(instruction), 32'h0000);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_strobes", 32'(strb), 32'h00);

        // Full program, filler run through 0xFE, then HALT at 0xFF.
        stall_lo = 56;
        stall_hi = 57;
        push_program();
        t = 61;
        for (int a = 10; a < 255; a++) begin
            if (a == 8'h12 || a == 8'h40) begin
                push(t + 3, EV_LA, NSEL_RN, 2'b00, 0, 0, 8'h00, 16'h0000, 8'(a + 1));
                push(t + 4, EV_LB, NSEL_RM, 2'b00, 0, 0, 8'h00, 16'h0000, 8'(a + 1));
                push(t + 5, EV_LS, 3'b000,  2'b00, 0, 0, 8'h00, 16'h0000, 8'(a + 1));
                t += 6;
            end else begin
                push(t + 3, EV_W, NSEL_RN, VSEL_IMM, 0, 0, 8'h00,
                     {{8{a[7]}}, a[7:0]}, 8'(a + 1));
                t += 4;
            end
        end
        halt_cyc = t + 3;
        release_reset();
        while (cyc < halt_cyc + 100) tick();
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc_wrapped", 32'(pc), 32'h00);
        check("halt_strobes", 32'(strb), 32'h00);
        check("store_ram_0x12", 32'(ram[8'h12]), 32'hABCD);
        check("queue_drained_a", 32'(q.size()), 32'h0);

        // Asynchronous reset out of HALT, mid-cycle.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_halted", 32'(halted), 32'h0);
        check("async_rst_pc", 32'(pc), 32'h00);

        // Rerun and abort inside MEM_WR of the STR.
        stall_lo   = -1;
        stall_hi   = -1;
        ram_clear  = 1'b1;
        @(posedge clk);
        #1;
        ram_clear  = 1'b0;
        push_limit = 38;
        push_program();
        release_reset();
        while (cyc < 38) tick();
        check("memwr_we_before_rst", 32'(mem_we), 32'h1);
        check("memwr_addr_before_rst", 32'(mem_addr), 32'h12);
        #2;
        reset_n = 1'b0;
        #1;
        check("memwr_we_after_rst", 32'(mem_we), 32'h0);
        check("memwr_pc_after_rst", 32'(pc), 32'h00);
        check("memwr_addr_after_rst", 32'(mem_addr), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        check("memwr_no_ram_write", 32'(written[8'h12]), 32'h0);
        check("queue_drained_b", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Parametrised multicycle controller for the Simple RISC Machine. It owns the program counter, instruction register and data-address register, and sequences the fetch/decode/execute FSM. Its outputs drive the existing datapath load/select strobes and a synchronous RAM port. It replaces manual key-clocked stepping with a free-running `clk` gated by `step_en`, and sits between the RAM, the instruction decoder and the datapath in the board top level.

## Interface
Parameters:
- `WORD_W`, 16: instruction/data width; minimum 16.
- `ADDR_W`, 8: RAM address width; PC width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `step_en`  in  1  advance enable; 0 freezes the FSM, PC, IR and address register.
- `mem_rdata`  in  WORD_W  RAM read data, valid one cycle after `mem_addr`.
- `datapath_out`  in  WORD_W  datapath C register.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_we`  out  1  RAM write strobe.
- `mem_wdata`  out  WORD_W  equals `datapath_out`.
- `instruction`  out  WORD_W  IR contents, fed to the decoder.
- `nsel`  out  3  one-hot register-field select: [0] Rm, [1] Rd, [2] Rn.
- `vsel`  out  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata.
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`  out  1 each  datapath strobes and selects.
- `pc`  out  ADDR_W  current PC.
- `halted`  out  1  FSM is in HALT.

## Operation
- Instruction fields: opcode = `instruction[15:13]`; op = `[12:11]`.
- Encodings:
  - 110/10 MOV imm.
  - 110/00 MOV reg.
  - 101/xx ALU: op 01 is CMP.
  - 011 LDR.
  - 100 STR.
  - 111 HALT.
  - Any other code halts.
- States:
  - FETCH: `mem_addr`=PC.
  - LOAD_IR: IR←`mem_rdata`; PC←PC+1, modulo 2^ADDR_W.
  - DECODE: no strobes; branch on opcode.
  - MOV imm: WR_IMM (nsel=Rn, vsel=10, write), then FETCH.
  - MOV reg: GET_B (nsel=Rm, loadb), EXEC (asel=1, loadc), WR_C (nsel=Rd, vsel=00, write), then FETCH.
  - ALU: GET_A (nsel=Rn, loada), GET_B, EXEC (loadc; CMP asserts loads instead of loadc), WR_C, then FETCH. CMP skips WR_C.
  - LDR: GET_A, ADDR (bsel=1, loadc), MEM_RD (`mem_addr`=`datapath_out[ADDR_W-1:0]`), LDR_WB (nsel=Rd, vsel=11, write), then FETCH.
  - STR: GET_A, ADDR, GET_RD (nsel=Rd, loadb; addr_reg←`datapath_out[ADDR_W-1:0]`), PASS (asel=1, bsel=0, loadc), MEM_WR (`mem_addr`=addr_reg, mem_we=1), then FETCH.
  - HALT: absorbing state, exited only by reset. `halted`=1.
- All strobes (`write`, `load*`, `mem_we`) are combinational decodes of the state ANDed with `step_en`. Selects (`nsel`, `vsel`, `asel`, `bsel`) and `mem_addr` are not gated.
- `step_en`=0 for any number of cycles resumes exactly where it stopped; no strobe repeats or is lost.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, PC=RESET_PC, IR=0, addr_reg=0.
  - All strobes 0; `halted`=0; `mem_addr`=RESET_PC.
- Cycles per instruction with `step_en`=1, including 3 for fetch/decode:
  - MOV imm 4.
  - MOV reg 6.
  - CMP 6.
  - ALU 7.
  - LDR 7.
  - STR 8.
- RAM read latency is exactly 1 cycle. LOAD_IR and LDR_WB consume `mem_rdata` one cycle after FETCH and MEM_RD respectively.
- Reset asserted mid-instruction aborts it. No partial write is issued after the reset edge.
- PC wraps from 2^ADDR_W−1 to 0 without a flag.

## Configuration
- `CPU_CTRL_RETIRE_CNT_EN` defined:
  - Adds output `retired` [31:0].
  - Increments by 1 on every transition into FETCH from a completed instruction.
  - Saturates at all-ones.
  - Reset value 0.
  - Frozen while in HALT.
- Not defined: port absent, counter logic absent. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode/op localparams.
  - State enum typedef.
  - nsel one-hot and vsel encoding constants.
- The decoder and datapath also import `cpu_pkg`.
- One sub-module, `pc_ir_reg`, holds PC, IR and addr_reg with their load/increment enables. The FSM stays in `cpu_controller`.

## Test plan
- Reset, then run with RAM[0]=MOV R0,#5 (0xD005): write=1 in cycle 4 with nsel=100, vsel=10; `pc`=1; next FETCH at cycle 5.
- ADD R2,R1,R0 with R0=5, R1=3: GET_A, GET_B, EXEC, WR_C each one cycle in order; write with nsel=010 in cycle 7; 7 cycles total.
- STR R3,[R1,#2] with R1=0x10, R3=0xABCD: `mem_we`=1 for one cycle with `mem_addr`=0x12 and `mem_wdata`=0xABCD. LDR back from the same address gives vsel=11 write.
- Toggle `step_en` 1-0-0-1 mid-ALU: each strobe asserts exactly once; total latency is the base count plus 2.
- HALT (0xE000) at PC=0xFF (ADDR_W=8): `halted`=1, `pc`=0x00 (wrapped), no strobes for 100 cycles; `reset_n` low clears `halted` asynchronously.
- Assert `reset_n` during MEM_WR: `mem_we` drops in the same cycle; state=FETCH, `pc`=RESET_PC.
